mul_issue_ctrl: RTL and testbench

Issue and retire controller for the 32-bit Booth/Wallace multiplier. It accepts RISC-V style multiply requests over a valid/ready handshake and drives the multiplier's operand and sign inputs. It tracks each in-flight operation through the multiplier's fixed latency, selects and corrects the 32-bit result half, and buffers results in a small output FIFO with credit-based backpressure.

---
 rtl/mul_issue_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue/retire controller for the 32-bit Booth/Wallace multiplier.
// Forwards operands to the multiplier on accept, follows each operation through
// the multiplier's fixed latency with a tag pipeline, then picks and corrects the
// result half and stores it in a response FIFO. Requests are credit-limited so the
// FIFO can never overflow, which is why the tag pipeline never stalls.
//
// Build option: define MUL_ISSUE_HSU_EN to get true MULHSU on op 11. The multiplier
// runs that op unsigned, and the high word is fixed up by subtracting rs2 whenever
// rs1 is negative. Without the macro the correction register is left out and
// op 11 behaves exactly like MULHU.
module mul_issue_ctrl #(
  parameter int MUL_LAT    = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        mul_clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  output logic        mul_signed,
  input  logic [63:0] mul_result,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + MUL_LAT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b11;

  logic acc;
  logic retire;
  logic pop;
  logic [31:0] retire_data;

  // Tag pipeline: stage 0 is loaded on the accept edge, and the last stage
  // lines up with the edge on which mul_result is valid.
  logic [MUL_LAT-1:0]       tag_vld_q, tag_vld_d;
  logic [MUL_LAT-1:0][1:0]  tag_op_q,  tag_op_d;
`ifdef MUL_ISSUE_HSU_EN
  logic [MUL_LAT-1:0][31:0] tag_corr_q, tag_corr_d;
  logic [31:0]              corr_new;
`endif

  logic [FIFO_DEPTH-1:0][31:0] mem_q, mem_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0]            inflight_q, inflight_d;
  logic [CNT_W-1:0]            outstanding_d;
  logic                        req_ready_q, req_ready_d;

  // Operands go straight to the multiplier; only MULH uses a signed array.
  // MULHSU is run unsigned and fixed up at retire (or left as MULHU).
  assign mul_x      = req_x;
  assign mul_y      = req_y;
  assign mul_signed = (req_op == OP_MULH);

  assign req_ready  = req_ready_q;
  assign resp_valid = (fifo_cnt_q != '0);
  assign resp_data  = mem_q[rd_ptr_q];
  assign busy       = (inflight_q != '0) | (fifo_cnt_q != '0);

  // Select the result half for the op leaving the tag pipeline.
  always_comb begin
    retire_data = mul_result[63:32];
    case (tag_op_q[MUL_LAT-1])
      OP_MUL:    retire_data = mul_result[31:0];
`ifdef MUL_ISSUE_HSU_EN
      OP_MULHSU: retire_data = mul_result[63:32] - tag_corr_q[MUL_LAT-1];
`endif
      default:   retire_data = mul_result[63:32];
    endcase
  end

  // Next-state logic for the tag pipeline, FIFO, counters and credit flag.
  always_comb begin
    acc    = req_valid & req_ready_q;
    retire = tag_vld_q[MUL_LAT-1];
    pop    = (fifo_cnt_q != '0) & resp_ready;

    tag_vld_d = tag_vld_q;
    tag_op_d  = tag_op_q;
    for (int i = MUL_LAT - 1; i > 0; i--) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_op_d[i]  = tag_op_q[i-1];
    end
    tag_vld_d[0] = acc;
    tag_op_d[0]  = req_op;

`ifdef MUL_ISSUE_HSU_EN
    corr_new   = ((req_op == OP_MULHSU) && req_x[31]) ? req_y : 32'h0;
    tag_corr_d = tag_corr_q;
    for (int i = MUL_LAT - 1; i > 0; i--) begin
      tag_corr_d[i] = tag_corr_q[i-1];
    end
    tag_corr_d[0] = corr_new;
`endif

    inflight_d = inflight_q;
    if (acc)    inflight_d = inflight_d + ONE_C;
    if (retire) inflight_d = inflight_d - ONE_C;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (retire) begin
      mem_d[wr_ptr_q] = retire_data;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
    end

    fifo_cnt_d = fifo_cnt_q;
    if (retire) fifo_cnt_d = fifo_cnt_d + ONE_C;
    if (pop)    fifo_cnt_d = fifo_cnt_d - ONE_C;

    // Credits cover both in-flight ops and buffered results, so a full count
    // means every future retire already has a FIFO slot reserved.
    outstanding_d = inflight_d + fifo_cnt_d;
    req_ready_d   = (outstanding_d < DEPTH_C);
  end

  // State registers; reset drops everything in flight and empties the FIFO.
  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      tag_vld_q   <= '0;
      tag_op_q    <= '0;
`ifdef MUL_ISSUE_HSU_EN
      tag_corr_q  <= '0;
`endif
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      inflight_q  <= '0;
      req_ready_q <= 1'b0;
    end else begin
      tag_vld_q   <= tag_vld_d;
      tag_op_q    <= tag_op_d;
`ifdef MUL_ISSUE_HSU_EN
      tag_corr_q  <= tag_corr_d;
`endif
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      inflight_q  <= inflight_d;
      req_ready_q <= req_ready_d;
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Testbench for mul_issue_ctrl (MUL_LAT=1, FIFO_DEPTH=2) with a behavioural multiplier.
module tb_mul_issue_ctrl;

  localparam int MUL_LAT    = 1;
  localparam int FIFO_DEPTH = 2;

`ifdef MUL_ISSUE_HSU_EN
  localparam logic [31:0] HSU_FF_EXP = 32'hFFFF_FFFF;
  localparam logic [31:0] HSU_NEG_EXP = 32'hFFFF_FFFE;
`else
  localparam logic [31:0] HSU_FF_EXP = 32'hFFFF_FFFE;
  localparam logic [31:0] HSU_NEG_EXP = 32'h0000_0001;
`endif

  logic        mul_clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic        mul_signed;
  logic [63:0] mul_result;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  mul_issue_ctrl #(.MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .mul_clk    (mul_clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_x      (req_x),
    .req_y      (req_y),
    .mul_x      (mul_x),
    .mul_y      (mul_y),
    .mul_signed (mul_signed),
    .mul_result (mul_result),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  always #5 mul_clk = ~mul_clk;

  // Behavioural multiplier: samples operands every edge, result MUL_LAT edges later.
  logic [63:0] prod_c;
  logic [63:0] mul_pipe [MUL_LAT];
  always_comb begin
    if (mul_signed)
      prod_c = {{32{mul_x[31]}}, mul_x} * {{32{mul_y[31]}}, mul_y};
    else
      prod_c = {32'h0, mul_x} * {32'h0, mul_y};
  end
  always @(posedge mul_clk) begin
    mul_pipe[0] <= prod_c;
    for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign mul_result = mul_pipe[MUL_LAT-1];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge mul_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One isolated request with resp_ready=1: accept, latency, data, drain.
  task automatic run_vec(input int idx);
    int n;
    req_op    = vecs[idx].op;
    req_x     = vecs[idx].x;
    req_y     = vecs[idx].y;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    check($sformatf("vec%0d ready", idx), {31'h0, req_ready}, 32'h1);
    check($sformatf("vec%0d mul_signed", idx), {31'h0, mul_signed},
          {31'h0, (vecs[idx].op == 2'b01)});
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin tick(); n++; end
    check($sformatf("vec%0d latency", idx), n, 32'd1);
    check($sformatf("vec%0d data", idx), resp_data, vecs[idx].exp);
    tick();
    check($sformatf("vec%0d drained", idx), {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int got;
    int n;
    logic rdy_s;
    int issued;

    vecs[0]  = '{2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[2]  = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
    vecs[3]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, HSU_FF_EXP};
    vecs[4]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[5]  = '{2'b11, 32'h8000_0000, 32'h0000_0003, HSU_NEG_EXP};
    vecs[6]  = '{2'b11, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFE};
    vecs[7]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[8]  = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780};
    vecs[9]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[10] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};

    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_x      = 32'h0;
    req_y      = 32'h0;
    resp_ready = 1'b1;

    // Reset values, then req_ready rises only at the first edge after release.
    tick();
    tick();
    check("rst req_ready", {31'h0, req_ready}, 32'h0);
    check("rst resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst resp_data", resp_data, 32'h0);
    check("rst busy", {31'h0, busy}, 32'h0);
    #3 resetn = 1'b1;
    #1;
    check("post-release ready low", {31'h0, req_ready}, 32'h0);
    tick();
    check("first edge ready", {31'h0, req_ready}, 32'h1);

    // Table-driven single ops.
    for (int i = 0; i < 11; i++) run_vec(i);

    // Backpressure: two accepts fill credits, a third request waits.
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_op     = 2'b00;
    req_x      = 32'd2; req_y = 32'd3;
    tick();
    check("bp ready after 1 accept", {31'h0, req_ready}, 32'h1);
    req_x = 32'd4; req_y = 32'd5;
    tick();
    check("bp ready after 2 accepts", {31'h0, req_ready}, 32'h0);
    check("bp busy", {31'h0, busy}, 32'h1);
    req_x = 32'd5; req_y = 32'd5;
    tick();
    check("bp head", resp_data, 32'd6);
    tick();
    check("bp ready held low", {31'h0, req_ready}, 32'h0);
    check("bp head stable", resp_data, 32'd6);
    resp_ready = 1'b1;
    tick();
    check("bp ready after first pop", {31'h0, req_ready}, 32'h1);
    check("bp second", resp_data, 32'd20);
    tick();
    req_valid = 1'b0;
    check("bp gap after drain", {31'h0, resp_valid}, 32'h0);
    tick();
    check("bp third valid", {31'h0, resp_valid}, 32'h1);
    check("bp third", resp_data, 32'd25);
    tick();
    check("bp idle", {31'h0, busy}, 32'h0);

    // Stream of 10 MULs i*i, in order, across pointer wraps.
    got = 0; issued = 0; n = 0;
    req_op = 2'b00;
    while (got < 10 && n < 200) begin
      if (issued < 10) begin
        req_valid = 1'b1;
        req_x = 32'(issued + 1);
        req_y = 32'(issued + 1);
      end else begin
        req_valid = 1'b0;
      end
      #0;
      rdy_s = req_ready;
      if (resp_valid) begin
        check($sformatf("stream %0d", got), resp_data, 32'((got + 1) * (got + 1)));
        got++;
      end
      tick();
      if (rdy_s && issued < 10) issued++;
      n++;
    end
    req_valid = 1'b0;
    check("stream count", got, 32'd10);
    tick();
    check("stream idle", {31'h0, busy}, 32'h0);

    // Reset with one op buffered and one in flight.
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_x = 32'd2; req_y = 32'd2;
    tick();
    req_x = 32'd3; req_y = 32'd4;
    tick();
    req_valid = 1'b0;
    check("pre-reset resp_valid", {31'h0, resp_valid}, 32'h1);
    #2 resetn = 1'b0;
    #1;
    check("mid rst resp_valid", {31'h0, resp_valid}, 32'h0);
    check("mid rst busy", {31'h0, busy}, 32'h0);
    check("mid rst req_ready", {31'h0, req_ready}, 32'h0);
    tick();
    #2 resetn = 1'b1;
    tick();
    tick();
    check("no stale resp", {31'h0, resp_valid}, 32'h0);
    check("no stale busy", {31'h0, busy}, 32'h0);
    resp_ready = 1'b1;
    vecs[0] = '{2'b00, 32'd3, 32'd3, 32'd9};
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
